// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU datapath: write-back source indices,
// the default slow-source mask and the write-back FSM state type.
package mcu_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_SCR = 1;
  localparam int SRC_SP  = 2;
  localparam int SRC_IN  = 3;

  // Scratch RAM read data arrives one cycle after its address is issued.
  localparam logic [3:0] SLOW_MASK_DFLT = 4'b0010;

  typedef enum logic {
    IDLE,
    WAIT_SLOW
  } wb_state_t;

endpackage

// File: rtl/wb_src_sel.sv
// Combinational NSRC:1 indexed select over a packed source bus, with a
// flag for indices that do not name a source.
module wb_src_sel #(
  parameter int DATA_W = 8,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [NSRC*DATA_W-1:0] src,
  output logic [DATA_W-1:0]      dat,
  output logic                   err
);

  // Pick the addressed slice; any index with no matching source raises err.
  always_comb begin
    dat = '0;
    err = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        dat = src[i*DATA_W +: DATA_W];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_wb_mux.sv
// Register-file write-back selector. Chooses one of NSRC sources, registers
// the data and address, and pulses RF_WR. Sources flagged in SLOW_MASK are
// sampled one cycle later, during which BUSY blocks new requests.
module rf_wb_mux
  import mcu_pkg::*;
#(
  parameter  int              DATA_W    = 8,
  parameter  int              ADDR_W    = 5,
  parameter  int              NSRC      = 4,
  parameter  logic [NSRC-1:0] SLOW_MASK = (NSRC)'(SLOW_MASK_DFLT),
  localparam int              SEL_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   WR_REQ,
  input  logic [SEL_W-1:0]       WR_SEL,
  input  logic [ADDR_W-1:0]      WR_ADR,
  input  logic [NSRC*DATA_W-1:0] SRC_DATA,
  output logic                   BUSY,
  output logic                   RF_WR,
  output logic [ADDR_W-1:0]      RF_ADR,
  output logic [DATA_W-1:0]      DIN_REG,
  output logic                   SEL_ERR
);

  wb_state_t         state, state_nxt;
  logic [SEL_W-1:0]  sel_p1;
  logic [ADDR_W-1:0] adr_p1;
  logic [SEL_W-1:0]  mux_sel;
  logic [DATA_W-1:0] mux_dat;
  logic              mux_err;
  logic              mux_slow;
  logic              busy;
  logic              accept;
  logic              wr_fast;
  logic              wr_slow;
  logic              slow_go;

  // While waiting on a slow source the captured select drives the mux,
  // so one selector serves both the fast and the delayed sample.
  assign mux_sel = (state == WAIT_SLOW) ? sel_p1 : WR_SEL;

  wb_src_sel #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC),
    .SEL_W  (SEL_W)
  ) u_sel (
    .sel (mux_sel),
    .src (SRC_DATA),
    .dat (mux_dat),
    .err (mux_err)
  );

  // Look up whether the selected source needs an extra cycle.
  always_comb begin
    mux_slow = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (mux_sel == SEL_W'(i)) mux_slow = SLOW_MASK[i];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a valid slow request parks in WAIT_SLOW for exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (slow_go) state_nxt = WAIT_SLOW;
      WAIT_SLOW: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Decoded control from the current state and request.
  always_comb begin
    busy    = (state == WAIT_SLOW);
    accept  = WR_REQ && !busy;
    wr_fast = accept && !mux_err && !mux_slow;
    slow_go = accept && !mux_err && mux_slow;
    wr_slow = busy;
  end

  assign BUSY = busy;

  // Stage 1: capture select and address of an accepted slow request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_p1 <= '0;
      adr_p1 <= '0;
    end else if (slow_go) begin
      sel_p1 <= WR_SEL;
      adr_p1 <= WR_ADR;
    end
  end

  // Output stage: write strobe, error pulse, and held write data/address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RF_WR   <= 1'b0;
      SEL_ERR <= 1'b0;
      RF_ADR  <= '0;
      DIN_REG <= '0;
    end else begin
      RF_WR   <= wr_fast || wr_slow;
      SEL_ERR <= accept && mux_err;
      if (wr_fast || wr_slow) begin
        DIN_REG <= mux_dat;
        RF_ADR  <= wr_slow ? adr_p1 : WR_ADR;
      end
    end
  end

endmodule

// File: doc/rf_wb_mux.md
Name: rf_wb_mux

Overview:
- Parametrised register-file write-back selector.
- Generalises the RF write-data select from a fixed 4-way combinational choice to NSRC sources of DATA_W bits.
- Registered output with a write strobe.
- Per-source latency alignment: single-cycle-read sources (scratch RAM) are waited on before the write is issued.
- Sits between the datapath sources (ALU, scratch RAM, stack pointer, input port) and the register file write port; driven by the control unit.

Parameters:
- DATA_W, 8: width of every source and of DIN_REG.
- ADDR_W, 5: register-file address width.
- NSRC, 4: number of write-back sources; source index = WR_SEL value.
- SEL_W, $clog2(NSRC) (min 1): select width, derived, not overridden.
- SLOW_MASK, 4'b0010: bit i set means source i delivers data one cycle after the request (source 1 = scratch RAM data out).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WR_REQ  in  1  write-back request from control unit.
- WR_SEL  in  SEL_W  source index.
- WR_ADR  in  ADDR_W  destination register.
- SRC_DATA  in  NSRC*DATA_W  packed sources; source i at [i*DATA_W +: DATA_W].
- BUSY  out  1  slow write in flight; new requests not accepted.
- RF_WR  out  1  register-file write strobe, one-cycle pulse.
- RF_ADR  out  ADDR_W  write address, valid with RF_WR.
- DIN_REG  out  DATA_W  write data, valid with RF_WR.
- SEL_ERR  out  1  one-cycle pulse on request with WR_SEL >= NSRC.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; BUSY, RF_WR, SEL_ERR = 0; RF_ADR, DIN_REG = 0; captured sel/adr = 0.
- States: IDLE, WAIT_SLOW.
- BUSY = (state == WAIT_SLOW), combinational from state.
- Accept condition: WR_REQ && !BUSY.
- Request while BUSY: ignored, no side effects. Control unit must hold or reissue it.
- Fast source (SLOW_MASK[sel] = 0), accepted in cycle N: at edge N+1, DIN_REG <= source sel sampled in cycle N, RF_ADR <= WR_ADR, RF_WR = 1 during cycle N+1. Latency 1. Back-to-back fast requests are accepted every cycle.
- Slow source (SLOW_MASK[sel] = 1), accepted in cycle N:
  - Capture sel/adr at edge N+1; state -> WAIT_SLOW.
  - In cycle N+1, sample source sel at edge N+2: DIN_REG/RF_ADR loaded, RF_WR = 1 during cycle N+2, state -> IDLE. Latency 2.
  - A request in cycle N+1 is ignored.
  - A request in cycle N+2 is accepted normally, so a fast request there writes in cycle N+3 and cannot collide.
- Invalid select (WR_SEL >= NSRC, possible only for non-power-of-two NSRC) when accepted: no write; SEL_ERR = 1 for one cycle at N+1; DIN_REG/RF_ADR hold.
- No-write cycles: RF_WR = 0; DIN_REG and RF_ADR hold their last written values. Explicit registers only, no inferred latches.
- Reset asserted during WAIT_SLOW aborts the write: no RF_WR pulse after release.
- Width rules: selection is a pure index into SRC_DATA; no arithmetic; no truncation or extension.
- WR_ADR is captured only at accept; later changes have no effect on an in-flight write.

Decomposition:
- Shared package mcu_pkg holds:
  - localparams for source indices: SRC_ALU = 0, SRC_SCR = 1, SRC_SP = 2, SRC_IN = 3;
  - default SLOW_MASK;
  - the state enum typedef wb_state_t {IDLE, WAIT_SLOW}.
- One sub-module is natural: wb_src_sel, a purely combinational NSRC:1 indexed select with an out-of-range flag. It is instantiated once; the FSM and registers live in rf_wb_mux.

Test Plan:
- Reset: hold RST_N = 0 with SRC_DATA driven nonzero -> RF_WR = 0, DIN_REG = 8'h00, RF_ADR = 0, BUSY = 0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Fast write: cycle N, WR_REQ = 1, WR_SEL = 0, WR_ADR = 5'd7, ALU = 8'hA5 -> cycle N+1: RF_WR = 1, RF_ADR = 7, DIN_REG = 8'hA5. Cycle N+2: RF_WR = 0, DIN_REG holds 8'hA5.
- Slow write: cycle N, WR_SEL = 1, WR_ADR = 5'd3. SCR = 8'hFF in N, 8'h3C in N+1 -> BUSY = 1 in N+1; RF_WR = 1 in N+2 with DIN_REG = 8'h3C, RF_ADR = 3.
- Collision guard:
  - slow request in N, then fast request (sel 3, IN = 8'h11, adr 9) held through N+1 and N+2 -> N+1 request ignored;
  - slow write completes in N+2;
  - fast write in N+3 with DIN_REG = 8'h11, RF_ADR = 9;
  - exactly two RF_WR pulses total.
- Back-to-back fast: sel 0, 2, 3 in consecutive cycles with distinct data -> three consecutive RF_WR pulses with matching data and addresses.
- Abort and invalid select:
  - reset asserted during WAIT_SLOW -> no RF_WR after release;
  - with NSRC = 3, WR_SEL = 3 -> SEL_ERR pulse, no RF_WR, DIN_REG unchanged.
